logic_op_issuer: RTL

- Upstream issue/collect front-end for the registered logic unit.
- Accepts operation requests on a valid/ready channel and drives the unit's operand inputs (opA, opB, operation select).
- Tracks the unit's fixed result latency and captures each result with its request tag into a response FIFO.
- Returns results in order on a valid/ready channel with full backpressure; sits between the decode/dispatch stage and writeback.

---
 rtl/logic_op_issuer_pkg.sv | 31 +++
 rtl/logic_op_issuer_resp_fifo.sv | 62 ++++++
 rtl/logic_op_issuer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/logic_op_issuer_pkg.sv
// Shared types and constants for the logic-unit issue/collect slice.
package logic_op_issuer_pkg;

  // Operation select understood by the logic unit: OP0=XOR, OP1=OR, anything else AND.
  typedef enum logic [1:0] {
    OP0 = 2'd0,
    OP1 = 2'd1,
    OP2 = 2'd2,
    OP3 = 2'd3
  } instruction_type;

  // Result latency of the registered logic unit, shared so unit and issuer agree.
  localparam int LU_LAT_DEF = 1;

  // Default tag width used by the response entry view.
  localparam int TAG_W_DEF = 4;

  // One buffered response: unit result plus the request tag it belongs to.
  typedef struct packed {
    logic [31:0]          result;
    logic [TAG_W_DEF-1:0] tag;
  } resp_entry_t;

  // Occupancy class of the issuer: empty, partially used, no credits left.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } issue_state_t;

endpackage

// File: rtl/logic_op_issuer_resp_fifo.sv
// First-word-fall-through response FIFO with synchronous flush and count output.
module resp_fifo
  import logic_op_issuer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head entry is visible without a pop; an empty FIFO presents zeros.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array needs no reset; the count decides what is visible.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and count bookkeeping; flush wins over any push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push_ok) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/logic_op_issuer.sv
// Issue/collect front-end: feeds the registered logic unit, tracks its latency
// with a tag pipe, and returns tagged results in order through a response FIFO.
module logic_op_issuer
  import logic_op_issuer_pkg::*;
#(
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4,
  parameter int LU_LAT = LU_LAT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_opA,
  input  logic [31:0]     req_opB,
  input  instruction_type req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic            flush,
  output logic [31:0]     lu_opA,
  output logic [31:0]     lu_opB,
  output instruction_type lu_op,
  input  logic [31:0]     lu_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [31:0]     rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

  issue_state_t     state, next_state;
  logic [LU_LAT:0]  pipe_v;
  logic [TAG_W-1:0] pipe_tag [LU_LAT+1];
  logic [CW-1:0]    inflight, next_inflight;
  logic [CW-1:0]    fifo_count, next_fifo_count;
  logic [CW:0]      next_occ;
  logic             accept, capture, push, pop, fifo_empty;
  logic [31+TAG_W:0] fifo_out;

  // Credits come only from registered state, so pops free a slot next cycle.
  assign req_ready = !reset && (state != FULL) && !flush;
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;
  assign capture   = pipe_v[LU_LAT];
  assign push      = capture && !flush;
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready && !flush;
  assign rsp_result = fifo_out[31+TAG_W:TAG_W];
  assign rsp_tag    = fifo_out[TAG_W-1:0];

  // Operand registers toward the logic unit; they hold when nothing is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lu_opA <= '0;
      lu_opB <= '0;
      lu_op  <= OP0;
    end else if (accept) begin
      lu_opA <= req_opA;
      lu_opB <= req_opB;
      lu_op  <= req_op;
    end
  end

  // Tag/valid shift pipe matching the unit latency; the last stage marks capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v <= '0;
      for (int i = 0; i <= LU_LAT; i++) pipe_tag[i] <= '0;
    end else if (flush) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0]   <= accept;
      pipe_tag[0] <= req_tag;
      for (int i = 1; i <= LU_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // Count of ops issued but not yet captured into the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      inflight <= '0;
    else if (flush) inflight <= '0;
    else            inflight <= next_inflight;
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next occupancy from this cycle's accept/capture/push/pop, classified into a state.
  always_comb begin
    next_inflight   = inflight;
    next_fifo_count = fifo_count;
    next_state      = state;
    if (accept && !capture)      next_inflight = inflight + CW'(1);
    else if (capture && !accept) next_inflight = inflight - CW'(1);
    if (push && !pop)            next_fifo_count = fifo_count + CW'(1);
    else if (pop && !push)       next_fifo_count = fifo_count - CW'(1);
    next_occ = {1'b0, next_fifo_count} + {1'b0, next_inflight};
    if (flush)                    next_state = IDLE;
    else if (next_occ == '0)      next_state = IDLE;
    else if (next_occ >= DEPTH_V) next_state = FULL;
    else                          next_state = RUN;
  end

  resp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32 + TAG_W)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({lu_result, pipe_tag[LU_LAT]}),
    .pop       (pop),
    .flush     (flush),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule
